// File: rtl/pkt_wr_ctrl.sv
// -----------------------------------------------------------------------------
// pkt_wr_ctrl
//
// Purpose
//   Write-side controller for a circular packet buffer. It takes a byte stream
//   framed by sop/eop (no backpressure) and writes the bytes into a packet SRAM
//   through a registered write port. A packet that arrives in full is
//   committed: a one-cycle descriptor carries its start address and byte
//   count. A packet that cannot be stored is discarded: its bytes are released
//   by moving the write pointer back to the packet start, and o_drop pulses.
//
//   o_free_space counts the bytes not held by committed packets. It shrinks
//   when a packet commits and grows when the downstream reader returns space
//   through i_free/i_free_len. The bytes of a packet still being received are
//   counted separately (len), so an uncommitted packet can never run over data
//   that the reader has not yet released.
//
// Ports
//   i_clk            sole clock, rising edge
//   i_rst            synchronous, active-high reset
//   i_valid          input byte valid this cycle
//   i_sop / i_eop    first / last byte of a packet (qualified by i_valid)
//   i_data           input byte
//   o_mem_write      SRAM write strobe (registered)
//   o_mem_addr       SRAM write address (registered)
//   o_mem_data       SRAM write data (registered)
//   o_desc_valid     one-cycle pulse: packet committed
//   o_desc_addr      committed packet start address
//   o_desc_len       committed packet byte count, 1..DEPTH
//   i_free           reader releases space this cycle
//   i_free_len       number of bytes released
//   o_free_space     bytes not held by committed packets
//   o_drop           one-cycle pulse: packet discarded
// -----------------------------------------------------------------------------
module pkt_wr_ctrl #(
    parameter int  DATA_WIDTH = 8,
    parameter int  DEPTH      = 3072,
    localparam int AW         = $clog2(DEPTH),
    localparam int LW         = $clog2(DEPTH + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    input  logic                  i_sop,
    input  logic                  i_eop,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_mem_write,
    output logic [AW-1:0]         o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_data,
    output logic                  o_desc_valid,
    output logic [AW-1:0]         o_desc_addr,
    output logic [LW-1:0]         o_desc_len,
    input  logic                  i_free,
    input  logic [LW-1:0]         i_free_len,
    output logic [LW-1:0]         o_free_space,
    output logic                  o_drop
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,   // between packets
        RECV = 2'b01,   // storing the bytes of an open packet
        DROP = 2'b10    // discarding the rest of a rejected packet
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [LW-1:0] DEPTH_LEN = LW'(DEPTH);
    localparam logic [LW:0]   DEPTH_EXT = (LW + 1)'(DEPTH);

    state_t        state;
    logic [AW-1:0] wr_ptr;      // next SRAM address to write
    logic [AW-1:0] start_addr;  // first address of the open packet
    logic [LW-1:0] len;         // bytes accepted so far for the open packet

    // Per-cycle decode of the incoming byte.
    logic          in_pkt;      // a packet is open (RECV)
    logic          room;        // one more byte fits without touching committed data
    logic          sop_seen;    // sop outside an open packet (IDLE or DROP)
    logic          accept;      // byte is written to the SRAM
    logic          commit;      // accepted byte closes the packet
    logic          abort;       // open packet is rolled back
    logic          drop_now;    // some packet is discarded this cycle
    logic [LW-1:0] len_incl;    // packet length including this byte
    logic [AW-1:0] commit_addr; // start address of the packet being committed
    logic [AW-1:0] wr_ptr_inc;  // wr_ptr advanced by one with wrap
    logic [LW:0]   freed;       // one extra bit: free space plus a release
    logic [LW:0]   committed;   //   can reach 2*DEPTH before the clamp
    logic [LW:0]   space_sum;
    logic [LW-1:0] free_next;

    // NOTE: every signal in this block is assigned on every pass, so no
    // latch can be inferred; adding a conditional assignment here without a
    // preceding default would create one.
    always_comb begin
        in_pkt      = (state == RECV);

        // Outside a packet nothing is accepted yet, so one free byte is enough.
        room        = in_pkt ? (len < o_free_space) : (o_free_space != '0);

        sop_seen    = i_valid && i_sop && !in_pkt;
        accept      = i_valid && room && (in_pkt ? !i_sop : i_sop);
        commit      = accept && i_eop;

        // A sop inside an open packet, or running out of room, kills the
        // open packet; the new sop byte itself is never stored.
        abort       = i_valid && in_pkt && (i_sop || !room);
        drop_now    = abort || (sop_seen && !room);

        len_incl    = in_pkt ? (len + LW'(1)) : LW'(1);

        // A single-byte packet starts at the current write pointer.
        commit_addr = in_pkt ? start_addr : wr_ptr;

        wr_ptr_inc  = (wr_ptr == LAST_ADDR) ? '0 : (wr_ptr + AW'(1));

        // Release and commit in the same cycle fold into one update. The
        // committed length never exceeds the current free space, so the
        // subtraction cannot underflow.
        freed       = i_free ? {1'b0, i_free_len} : '0;
        committed   = commit ? {1'b0, len_incl} : '0;
        space_sum   = {1'b0, o_free_space} + freed - committed;
        free_next   = (space_sum > DEPTH_EXT) ? DEPTH_LEN : space_sum[LW-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments so that every
    // register in this block is computed from values sampled before the edge,
    // independent of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // Reset wins over any byte or release in the same cycle; an open
            // packet vanishes without a drop pulse or descriptor.
            state        <= IDLE;
            wr_ptr       <= '0;
            start_addr   <= '0;
            len          <= '0;
            o_mem_write  <= 1'b0;
            o_mem_addr   <= '0;
            o_mem_data   <= '0;
            o_desc_valid <= 1'b0;
            o_desc_addr  <= '0;
            o_desc_len   <= '0;
            o_free_space <= DEPTH_LEN;
            o_drop       <= 1'b0;
        end else begin
            o_mem_write  <= accept;
            o_desc_valid <= commit;
            o_drop       <= drop_now;
            o_free_space <= free_next;

            if (accept) begin
                o_mem_addr <= wr_ptr;
                o_mem_data <= i_data;
                wr_ptr     <= wr_ptr_inc;
            end else if (abort) begin
                // Give the discarded bytes back to the next packet.
                wr_ptr <= start_addr;
            end

            if (accept && !in_pkt) begin
                start_addr <= wr_ptr;
            end

            if (commit) begin
                o_desc_addr <= commit_addr;
                o_desc_len  <= len_incl;
            end

            if (commit || drop_now) begin
                len <= '0;
            end else if (accept) begin
                len <= len_incl;
            end

            // Frame tracking: an eop always closes whatever was in progress,
            // whether the packet was stored, rejected or being skipped.
            if (accept) begin
                state <= i_eop ? IDLE : RECV;
            end else if (drop_now) begin
                state <= i_eop ? IDLE : DROP;
            end else if ((state == DROP) && i_valid && i_eop) begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_pkt_wr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pkt_wr_ctrl
//
// Purpose
//   Self-checking bench for pkt_wr_ctrl with DEPTH=16. Scenario tasks drive the
//   byte stream and push the expected SRAM writes, descriptors and drop pulses
//   (each stamped with the cycle it must appear in) onto queues; a monitor on
//   the falling edge pops and compares them as the DUT produces them. Free
//   space and reset values are compared inline by the scenario tasks.
// -----------------------------------------------------------------------------
module tb_pkt_wr_ctrl;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int LW    = 5;

    logic          i_clk;
    logic          i_rst;
    logic          i_valid;
    logic          i_sop;
    logic          i_eop;
    logic [DW-1:0] i_data;
    logic          o_mem_write;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_data;
    logic          o_desc_valid;
    logic [AW-1:0] o_desc_addr;
    logic [LW-1:0] o_desc_len;
    logic          i_free;
    logic [LW-1:0] i_free_len;
    logic [LW-1:0] o_free_space;
    logic          o_drop;

    pkt_wr_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_valid      (i_valid),
        .i_sop        (i_sop),
        .i_eop        (i_eop),
        .i_data       (i_data),
        .o_mem_write  (o_mem_write),
        .o_mem_addr   (o_mem_addr),
        .o_mem_data   (o_mem_data),
        .o_desc_valid (o_desc_valid),
        .o_desc_addr  (o_desc_addr),
        .o_desc_len   (o_desc_len),
        .i_free       (i_free),
        .i_free_len   (i_free_len),
        .o_free_space (o_free_space),
        .o_drop       (o_drop)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;   // falling-edge cycle the output must be seen in
        int a;     // address
        int b;     // data or length
    } exp_t;

    exp_t wr_q[$];
    exp_t desc_q[$];
    exp_t drop_q[$];
    exp_t mon_e;

    int n_checks = 0;
    int n_fail   = 0;
    int ptr      = 0;   // where the bench expects the next packet to start

    // ---------------------------------------------------------------- monitor
    always @(negedge i_clk) begin
        while (wr_q.size() > 0 && wr_q[0].cyc < cyc) begin
            mon_e = wr_q.pop_front();
            n_checks++; n_fail++;
            $display("FAIL mem_write_missing: got no write at cycle %0d, required addr %0d data %0h",
                     mon_e.cyc, mon_e.a, mon_e.b);
        end
        if (o_mem_write === 1'b1) begin
            n_checks++;
            if (wr_q.size() == 0 || wr_q[0].cyc != cyc) begin
                n_fail++;
                $display("FAIL mem_write_unexpected: got write addr %0d data %0h at cycle %0d, required none",
                         o_mem_addr, o_mem_data, cyc);
            end else begin
                mon_e = wr_q.pop_front();
                if (o_mem_addr !== mon_e.a[AW-1:0] || o_mem_data !== mon_e.b[DW-1:0]) begin
                    n_fail++;
                    $display("FAIL mem_write: got addr %0d data %0h, required addr %0d data %0h",
                             o_mem_addr, o_mem_data, mon_e.a, mon_e.b);
                end
            end
        end

        while (desc_q.size() > 0 && desc_q[0].cyc < cyc) begin
            mon_e = desc_q.pop_front();
            n_checks++; n_fail++;
            $display("FAIL desc_missing: got no descriptor at cycle %0d, required addr %0d len %0d",
                     mon_e.cyc, mon_e.a, mon_e.b);
        end
        if (o_desc_valid === 1'b1) begin
            n_checks++;
            if (desc_q.size() == 0 || desc_q[0].cyc != cyc) begin
                n_fail++;
                $display("FAIL desc_unexpected: got addr %0d len %0d at cycle %0d, required none",
                         o_desc_addr, o_desc_len, cyc);
            end else begin
                mon_e = desc_q.pop_front();
                if (o_desc_addr !== mon_e.a[AW-1:0] || o_desc_len !== mon_e.b[LW-1:0]) begin
                    n_fail++;
                    $display("FAIL desc: got addr %0d len %0d, required addr %0d len %0d",
                             o_desc_addr, o_desc_len, mon_e.a, mon_e.b);
                end
            end
        end

        while (drop_q.size() > 0 && drop_q[0].cyc < cyc) begin
            mon_e = drop_q.pop_front();
            n_checks++; n_fail++;
            $display("FAIL drop_missing: got no drop at cycle %0d, required a drop pulse", mon_e.cyc);
        end
        if (o_drop === 1'b1) begin
            n_checks++;
            if (drop_q.size() == 0 || drop_q[0].cyc != cyc) begin
                n_fail++;
                $display("FAIL drop_unexpected: got drop at cycle %0d, required none", cyc);
            end else begin
                mon_e = drop_q.pop_front();
            end
        end
    end

    // ------------------------------------------------------ stimulus helpers
    task automatic drive(input logic v, input logic s, input logic e,
                         input logic [7:0] d, input logic f, input int fl);
        @(negedge i_clk);
        i_valid    = v;
        i_sop      = s;
        i_eop      = e;
        i_data     = d;
        i_free     = f;
        i_free_len = LW'(fl);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 0);
    endtask

    task automatic release_space(input int n);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, n);
    endtask

    // Expectations for the byte/frame just driven: visible one cycle later.
    function automatic void exp_wr(input int a, input int d);
        wr_q.push_back('{cyc + 1, a, d});
    endfunction

    function automatic void exp_desc(input int a, input int l);
        desc_q.push_back('{cyc + 1, a, l});
    endfunction

    function automatic void exp_drop();
        drop_q.push_back('{cyc + 1, 0, 0});
    endfunction

    // A packet that fits: every byte written from ptr, one descriptor.
    task automatic send_good_pkt(input int n, input int d0);
        int start;
        start = ptr;
        for (int i = 0; i < n; i++) begin
            drive(1'b1, i == 0, i == n - 1, 8'(d0 + i), 1'b0, 0);
            exp_wr(ptr, (d0 + i) & 255);
            ptr = (ptr + 1) % DEPTH;
        end
        exp_desc(start, n);
    endtask

    // -------------------------------------------------------------- scenarios
    task automatic test_reset();
        i_rst = 1'b1;
        i_valid = 1'b0; i_sop = 1'b0; i_eop = 1'b0; i_data = '0;
        i_free = 1'b0; i_free_len = '0;
        repeat (3) @(negedge i_clk);
        n_checks++;
        if (o_free_space !== 5'd16) begin
            n_fail++; $display("FAIL reset_free_space: got %0d, required 16", o_free_space);
        end
        n_checks++;
        if ({o_mem_write, o_desc_valid, o_drop} !== 3'b000) begin
            n_fail++; $display("FAIL reset_pulses: got write/desc/drop %b, required 000",
                               {o_mem_write, o_desc_valid, o_drop});
        end
        n_checks++;
        if (o_mem_addr !== 4'd0 || o_desc_addr !== 4'd0 || o_desc_len !== 5'd0 || o_mem_data !== 8'd0) begin
            n_fail++; $display("FAIL reset_values: got mem_addr %0d desc_addr %0d desc_len %0d data %0h, required 0",
                               o_mem_addr, o_desc_addr, o_desc_len, o_mem_data);
        end
        i_rst = 1'b0;
        ptr = 0;
    endtask

    task automatic test_basic();
        send_good_pkt(4, 8'hA0);        // addr 0..3, desc (0,4)
        idle(2);
        n_checks++;
        if (o_free_space !== 5'd12) begin
            n_fail++; $display("FAIL basic_free_space: got %0d, required 12", o_free_space);
        end
        release_space(4);
        idle(1);
        n_checks++;
        if (o_free_space !== 5'd16) begin
            n_fail++; $display("FAIL basic_release: got %0d, required 16", o_free_space);
        end
    endtask

    task automatic test_wrap();
        send_good_pkt(10, 8'h10);       // addr 4..13
        idle(1);
        release_space(10);
        idle(1);
        // wr_ptr now 14 with all 16 bytes free: packet wraps 14,15,0,1.
        send_good_pkt(4, 8'hD0);
        idle(2);
        n_checks++;
        if (o_free_space !== 5'd12) begin
            n_fail++; $display("FAIL wrap_free_space: got %0d, required 12", o_free_space);
        end
        release_space(4);
        idle(1);
    endtask

    task automatic test_free_clamp();
        release_space(5);               // 16 + 5 clamps to 16
        idle(1);
        n_checks++;
        if (o_free_space !== 5'd16) begin
            n_fail++; $display("FAIL free_clamp: got %0d, required 16", o_free_space);
        end
    endtask

    task automatic test_overflow();
        send_good_pkt(13, 8'h20);       // addr 2..14, leaves 3 free
        idle(2);
        n_checks++;
        if (o_free_space !== 5'd3) begin
            n_fail++; $display("FAIL overflow_setup: got %0d, required 3", o_free_space);
        end
        // 5-byte packet into 3 free bytes: 3 writes from 15, drop on byte 4.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, i == 0, i == 4, 8'(8'hB0 + i), 1'b0, 0);
            if (i < 3) exp_wr((15 + i) % DEPTH, 8'hB0 + i);
            if (i == 3) exp_drop();
        end
        idle(2);
        n_checks++;
        if (o_free_space !== 5'd3) begin
            n_fail++; $display("FAIL overflow_free_space: got %0d, required 3", o_free_space);
        end
        ptr = 15;                       // rolled back to the old start
        send_good_pkt(1, 8'hC0);        // addr 15, desc (15,1)
        idle(2);
        n_checks++;
        if (o_free_space !== 5'd2) begin
            n_fail++; $display("FAIL overflow_next_pkt: got %0d, required 2", o_free_space);
        end
        release_space(14);
        idle(1);
        n_checks++;
        if (o_free_space !== 5'd16) begin
            n_fail++; $display("FAIL overflow_release: got %0d, required 16", o_free_space);
        end
    endtask

    task automatic test_abort();
        drive(1'b1, 1'b1, 1'b0, 8'hE0, 1'b0, 0); exp_wr(0, 8'hE0);
        drive(1'b1, 1'b0, 1'b0, 8'hE1, 1'b0, 0); exp_wr(1, 8'hE1);
        drive(1'b1, 1'b1, 1'b0, 8'hF0, 1'b0, 0); exp_drop();   // sop mid-packet
        drive(1'b1, 1'b0, 1'b0, 8'hF1, 1'b0, 0);               // skipped
        drive(1'b1, 1'b0, 1'b1, 8'hF2, 1'b0, 0);               // skipped, back to IDLE
        drive(1'b1, 1'b0, 1'b0, 8'hF3, 1'b0, 0);               // no sop in IDLE: ignored
        ptr = 0;
        send_good_pkt(3, 8'h30);        // from original start: addr 0..2
        idle(2);
        n_checks++;
        if (o_free_space !== 5'd13) begin
            n_fail++; $display("FAIL abort_free_space: got %0d, required 13", o_free_space);
        end
        release_space(3);
        idle(1);
    endtask

    task automatic test_same_cycle_free();
        send_good_pkt(6, 8'h50);        // addr 3..8, leaves 10 free
        idle(2);
        n_checks++;
        if (o_free_space !== 5'd10) begin
            n_fail++; $display("FAIL same_cycle_setup: got %0d, required 10", o_free_space);
        end
        drive(1'b1, 1'b1, 1'b1, 8'h77, 1'b1, 6);
        exp_wr(9, 8'h77);
        exp_desc(9, 1);
        ptr = 10;
        idle(2);
        n_checks++;
        if (o_free_space !== 5'd15) begin
            n_fail++; $display("FAIL same_cycle_free: got %0d, required 15", o_free_space);
        end
        release_space(1);
        idle(1);
    endtask

    task automatic test_back_to_back();
        send_good_pkt(2, 8'h60);        // addr 10,11
        send_good_pkt(2, 8'h68);        // addr 12,13 on the very next cycle
        idle(2);
        n_checks++;
        if (o_free_space !== 5'd12) begin
            n_fail++; $display("FAIL back_to_back_free: got %0d, required 12", o_free_space);
        end
        release_space(4);
        idle(1);
    endtask

    task automatic test_no_room();
        send_good_pkt(16, 8'h80);       // addr 14..13, fills the buffer
        idle(2);
        n_checks++;
        if (o_free_space !== 5'd0) begin
            n_fail++; $display("FAIL no_room_setup: got %0d, required 0", o_free_space);
        end
        drive(1'b1, 1'b1, 1'b0, 8'h90, 1'b0, 0); exp_drop();
        drive(1'b1, 1'b0, 1'b0, 8'h91, 1'b0, 0);
        drive(1'b1, 1'b0, 1'b1, 8'h92, 1'b0, 0);
        drive(1'b1, 1'b1, 1'b1, 8'h93, 1'b0, 0); exp_drop();   // sop+eop, no room
        idle(2);
        n_checks++;
        if (o_free_space !== 5'd0) begin
            n_fail++; $display("FAIL no_room_free: got %0d, required 0", o_free_space);
        end
        release_space(16);
        idle(1);
        n_checks++;
        if (o_free_space !== 5'd16) begin
            n_fail++; $display("FAIL no_room_release: got %0d, required 16", o_free_space);
        end
    endtask

    task automatic test_reset_mid_packet();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, i == 0, 1'b0, 8'(8'hC4 + i), 1'b0, 0);
            exp_wr((ptr + i) % DEPTH, 8'hC4 + i);
        end
        // Reset together with a byte and a release: both must be ignored.
        drive(1'b1, 1'b0, 1'b0, 8'hC7, 1'b1, 3);
        i_rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 0);
        n_checks++;
        if (o_free_space !== 5'd16) begin
            n_fail++; $display("FAIL reset_mid_free: got %0d, required 16", o_free_space);
        end
        n_checks++;
        if ({o_mem_write, o_desc_valid, o_drop} !== 3'b000) begin
            n_fail++; $display("FAIL reset_mid_pulses: got write/desc/drop %b, required 000",
                               {o_mem_write, o_desc_valid, o_drop});
        end
        i_rst = 1'b0;
        ptr = 0;
        send_good_pkt(1, 8'h99);        // wr_ptr back at 0
        idle(2);
        n_checks++;
        if (o_free_space !== 5'd15) begin
            n_fail++; $display("FAIL reset_mid_next: got %0d, required 15", o_free_space);
        end
    endtask

    // ------------------------------------------------------------------- main
    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_free_clamp();
        test_overflow();
        test_abort();
        test_same_cycle_free();
        test_back_to_back();
        test_no_room();
        test_reset_mid_packet();
        idle(3);

        n_checks++;
        if (wr_q.size() != 0 || desc_q.size() != 0 || drop_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d writes %0d descs %0d drops pending, required 0",
                     wr_q.size(), desc_q.size(), drop_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test by 200000, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
